// File: rtl/neander_irq_pkg.sv
// Shared types and MMIO map for the interrupt controller.
// Build option IRQ_SYNC_EN (see irq_controller) does not affect this package.
package neander_irq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      SERVICE = 2'd2
   } irq_state_t;

   localparam logic [15:0] IRQ_EN_ADDR   = 16'hF030;
   localparam logic [15:0] IRQ_PEND_ADDR = 16'hF032;
   localparam logic [15:0] IRQ_EDGE_ADDR = 16'hF034;
   localparam logic [15:0] IRQ_VEC_ADDR  = 16'hF036;

   localparam int IRQ_SRC_TIMER = 0;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: lowest set index wins.
module irq_prio_enc #(
   parameter int NUM_SRC = 8,
   parameter int VEC_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req_i,
   output logic [VEC_W-1:0]   vec_o,
   output logic               valid_o
);

   // Scan from the top so the lowest set index is the last one written.
   always_comb begin
      vec_o   = '0;
      valid_o = |req_i;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req_i[i]) vec_o = VEC_W'(i);
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: pending/enable/edge registers, priority select, ack/EOI FSM.
// Define IRQ_SYNC_EN to insert a 2-flop synchroniser ahead of the source sampling flop.
module irq_controller
   import neander_irq_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int VEC_W   = $clog2(NUM_SRC)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               en_wr,
   input  logic               edge_wr,
   input  logic               pend_wr,
   input  logic [15:0]        wdata,
   output logic [NUM_SRC-1:0] irq_en,
   output logic [NUM_SRC-1:0] irq_edge,
   output logic [NUM_SRC-1:0] irq_pend,
   output logic               cpu_irq,
   input  logic               cpu_ack,
   input  logic               cpu_eoi,
   output logic [VEC_W-1:0]   irq_vec,
   output logic               in_service
);

   irq_state_t         state_q, state_d;
   logic [NUM_SRC-1:0] src_in, src_q, src_prev_q;
   logic [NUM_SRC-1:0] en_q, en_d, edge_q, edge_d, pend_q, pend_d;
   logic [NUM_SRC-1:0] wmask, rise, clr, to_edge, eligible;
   logic [VEC_W-1:0]   vec_q, vec_d, prio_vec;
   logic               prio_valid, accept;

`ifdef IRQ_SYNC_EN
   logic [NUM_SRC-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= irq_src;
         sync2_q <= sync1_q;
      end
   end

   assign src_in = sync2_q;
`else
   assign src_in = irq_src;
`endif

   if (NUM_SRC < 16) begin : g_wdata_hi
      logic unused_wdata;
      assign unused_wdata = ^wdata[15:NUM_SRC];
   end

   assign wmask    = wdata[NUM_SRC-1:0];
   assign eligible = pend_q & en_q;

   irq_prio_enc #(.NUM_SRC(NUM_SRC), .VEC_W(VEC_W)) u_prio (
      .req_i   (eligible),
      .vec_o   (prio_vec),
      .valid_o (prio_valid)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (prio_valid) state_d = ASSERT;
         ASSERT: begin
            if (cpu_ack && prio_valid) state_d = SERVICE;
            else if (!prio_valid)      state_d = IDLE;
         end
         SERVICE: if (cpu_eoi) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cpu_irq    = (state_q == ASSERT);
      in_service = (state_q == SERVICE);
      accept     = (state_q == ASSERT) && cpu_ack && prio_valid;
   end

   // Edge bits: set beats clear. Level bits just mirror src_q.
   always_comb begin
      en_d    = en_wr   ? wmask : en_q;
      edge_d  = edge_wr ? wmask : edge_q;
      rise    = src_q & ~src_prev_q;
      clr     = (pend_wr ? wmask : '0) | (accept ? (NUM_SRC'(1) << prio_vec) : '0);
      to_edge = edge_wr ? (wmask & ~edge_q) : '0;
      pend_d  = (edge_q & ((pend_q & ~clr) | rise)) | (~edge_q & src_q);
      pend_d  = pend_d & ~to_edge;
      vec_d   = vec_q;
      if (prio_valid && state_q != SERVICE) vec_d = prio_vec;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_q      <= '0;
         src_prev_q <= '0;
         en_q       <= '0;
         edge_q     <= '0;
         pend_q     <= '0;
         vec_q      <= '0;
      end else begin
         src_q      <= src_in;
         src_prev_q <= src_q;
         en_q       <= en_d;
         edge_q     <= edge_d;
         pend_q     <= pend_d;
         vec_q      <= vec_d;
      end
   end

   assign irq_en   = en_q;
   assign irq_edge = edge_q;
   assign irq_pend = pend_q;
   assign irq_vec  = vec_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller; expected vectors queued at ack, checked after.
module tb_irq_controller;

`ifdef IRQ_SYNC_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 3;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] irq_src;
   logic       en_wr, edge_wr, pend_wr;
   logic [15:0] wdata;
   logic [7:0] irq_en, irq_edge, irq_pend;
   logic       cpu_irq, cpu_ack, cpu_eoi, in_service;
   logic [2:0] irq_vec;

   int tests  = 0;
   int failed = 0;
   int vq[$];

   irq_controller #(.NUM_SRC(8)) dut (
      .clk(clk), .reset(reset), .irq_src(irq_src),
      .en_wr(en_wr), .edge_wr(edge_wr), .pend_wr(pend_wr), .wdata(wdata),
      .irq_en(irq_en), .irq_edge(irq_edge), .irq_pend(irq_pend),
      .cpu_irq(cpu_irq), .cpu_ack(cpu_ack), .cpu_eoi(cpu_eoi),
      .irq_vec(irq_vec), .in_service(in_service)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic do_reset;
      reset = 1'b1; irq_src = '0; en_wr = 0; edge_wr = 0; pend_wr = 0;
      wdata = '0; cpu_ack = 0; cpu_eoi = 0;
      tick; tick;
      reset = 1'b0;
      tick;
   endtask

   task automatic wr_en(input logic [15:0] d);
      en_wr = 1'b1; wdata = d; tick; en_wr = 1'b0; wdata = '0;
   endtask

   task automatic wr_edge(input logic [15:0] d);
      edge_wr = 1'b1; wdata = d; tick; edge_wr = 1'b0; wdata = '0;
   endtask

   task automatic wait_irq(output int n);
      n = 0;
      while (cpu_irq !== 1'b1 && n < 20) begin tick; n++; end
   endtask

   task automatic ack_and_check_vec(input string nm);
      int exp;
      exp = (vq.size() > 0) ? vq.pop_front() : -1;
      tests++;
      if (int'(irq_vec) !== exp) begin
         failed++; $display("FAIL %s: irq_vec got %0d expected %0d", nm, irq_vec, exp);
      end
   endtask

   task automatic test_reset;
      do_reset;
      tests++;
      if ({cpu_irq, in_service, irq_vec, irq_en, irq_edge, irq_pend} !== '0) begin
         failed++; $display("FAIL reset: cpu_irq=%b in_service=%b vec=%0d en=%h edge=%h pend=%h",
                            cpu_irq, in_service, irq_vec, irq_en, irq_edge, irq_pend);
      end
   endtask

   task automatic test_level_timer;
      int n;
      do_reset;
      wr_en(16'h0001);
      irq_src = 8'h01;
      wait_irq(n);
      tests++;
      if (n !== LAT || cpu_irq !== 1'b1) begin
         failed++; $display("FAIL level_latency: got %0d cycles irq=%b expected %0d", n, cpu_irq, LAT);
      end
      cpu_ack = 1'b1; vq.push_back(0); tick; cpu_ack = 1'b0;
      ack_and_check_vec("level_vec");
      tests++;
      if (in_service !== 1'b1 || cpu_irq !== 1'b0) begin
         failed++; $display("FAIL level_service: in_service=%b cpu_irq=%b expected 1/0", in_service, cpu_irq);
      end
      irq_src = 8'h00;
      repeat (LAT) tick;
      cpu_eoi = 1'b1; tick; cpu_eoi = 1'b0;
      repeat (3) tick;
      tests++;
      if (cpu_irq !== 1'b0 || in_service !== 1'b0) begin
         failed++; $display("FAIL level_eoi_idle: cpu_irq=%b in_service=%b expected 0/0", cpu_irq, in_service);
      end
   endtask

   task automatic test_priority;
      int n;
      do_reset;
      wr_en(16'h00FF);
      wr_edge(16'h0024);
      irq_src = 8'h24; tick; irq_src = 8'h00;
      wait_irq(n);
      tests++;
      if (cpu_irq !== 1'b1 || irq_vec !== 3'd2) begin
         failed++; $display("FAIL prio_first: irq=%b vec=%0d expected 1/2", cpu_irq, irq_vec);
      end
      cpu_ack = 1'b1; vq.push_back(2); tick; cpu_ack = 1'b0;
      ack_and_check_vec("prio_vec1");
      tests++;
      if (irq_pend !== 8'h20) begin
         failed++; $display("FAIL prio_pend_after_ack1: pend=%h expected 20", irq_pend);
      end
      cpu_eoi = 1'b1; tick; cpu_eoi = 1'b0;
      tests++;
      if (cpu_irq !== 1'b0) begin
         failed++; $display("FAIL prio_reassert_early: cpu_irq=%b expected 0", cpu_irq);
      end
      tick;
      tests++;
      if (cpu_irq !== 1'b1 || irq_vec !== 3'd5 || irq_pend !== 8'h20) begin
         failed++; $display("FAIL prio_second: irq=%b vec=%0d pend=%h expected 1/5/20", cpu_irq, irq_vec, irq_pend);
      end
      cpu_ack = 1'b1; vq.push_back(5); tick; cpu_ack = 1'b0;
      ack_and_check_vec("prio_vec2");
      tests++;
      if (irq_pend !== 8'h00 || in_service !== 1'b1) begin
         failed++; $display("FAIL prio_pend_after_ack2: pend=%h in_service=%b expected 00/1", irq_pend, in_service);
      end
   endtask

   task automatic test_spurious;
      int n;
      do_reset;
      wr_edge(16'h0008);
      wr_en(16'h0008);
      irq_src = 8'h08; tick; irq_src = 8'h00;
      wait_irq(n);
      tests++;
      if (cpu_irq !== 1'b1 || irq_vec !== 3'd3) begin
         failed++; $display("FAIL spur_assert: irq=%b vec=%0d expected 1/3", cpu_irq, irq_vec);
      end
      wr_en(16'h0000);
      tick;
      tests++;
      if (cpu_irq !== 1'b0 || in_service !== 1'b0 || irq_vec !== 3'd3 || irq_pend[3] !== 1'b1) begin
         failed++; $display("FAIL spur_idle: irq=%b svc=%b vec=%0d pend=%h expected 0/0/3/pend[3]=1",
                            cpu_irq, in_service, irq_vec, irq_pend);
      end
      cpu_ack = 1'b1; tick; cpu_ack = 1'b0;
      tests++;
      if (in_service !== 1'b0 || irq_pend[3] !== 1'b1) begin
         failed++; $display("FAIL stray_ack: in_service=%b pend=%h expected 0/pend[3]=1", in_service, irq_pend);
      end
   endtask

   task automatic test_ack_mask_race;
      int n;
      do_reset;
      wr_edge(16'h0008);
      wr_en(16'h0008);
      irq_src = 8'h08; tick; irq_src = 8'h00;
      wait_irq(n);
      cpu_ack = 1'b1; en_wr = 1'b1; wdata = 16'h0000; vq.push_back(3);
      tick;
      cpu_ack = 1'b0; en_wr = 1'b0;
      ack_and_check_vec("race_vec");
      tests++;
      if (in_service !== 1'b1 || irq_pend !== 8'h00 || irq_en !== 8'h00) begin
         failed++; $display("FAIL ack_mask_race: svc=%b pend=%h en=%h expected 1/00/00", in_service, irq_pend, irq_en);
      end
   endtask

   task automatic test_w1c_race;
      do_reset;
      wr_edge(16'h0002);
      irq_src = 8'h02; tick;
      pend_wr = 1'b1; wdata = 16'h0002; tick; pend_wr = 1'b0; wdata = '0;
      tests++;
      if (irq_pend[1] !== 1'b1) begin
         failed++; $display("FAIL w1c_race: pend=%h expected pend[1]=1", irq_pend);
      end
      pend_wr = 1'b1; wdata = 16'h0002; tick; pend_wr = 1'b0; wdata = '0;
      tests++;
      if (irq_pend[1] !== 1'b0) begin
         failed++; $display("FAIL w1c_clear: pend=%h expected pend[1]=0", irq_pend);
      end
      irq_src = 8'h12;
      repeat (3) tick;
      tests++;
      if (irq_pend !== 8'h10) begin
         failed++; $display("FAIL level_pend: pend=%h expected 10", irq_pend);
      end
      wr_edge(16'h0012);
      tests++;
      if (irq_pend !== 8'h00) begin
         failed++; $display("FAIL edge_switch_clear: pend=%h expected 00", irq_pend);
      end
      tick;
      tests++;
      if (irq_pend !== 8'h00 || irq_edge !== 8'h12) begin
         failed++; $display("FAIL edge_switch_hold: pend=%h edge=%h expected 00/12", irq_pend, irq_edge);
      end
      irq_src = 8'h00;
   endtask

   task automatic test_reset_mid_service;
      int n;
      do_reset;
      wr_en(16'h0001);
      irq_src = 8'h01;
      wait_irq(n);
      cpu_ack = 1'b1; tick; cpu_ack = 1'b0;
      tests++;
      if (in_service !== 1'b1) begin
         failed++; $display("FAIL rst_pre_service: in_service=%b expected 1", in_service);
      end
      #2 reset = 1'b1;
      #1;
      tests++;
      if (cpu_irq !== 1'b0 || in_service !== 1'b0 || irq_pend !== 8'h00 || irq_en !== 8'h00) begin
         failed++; $display("FAIL rst_async: irq=%b svc=%b pend=%h en=%h expected all 0",
                            cpu_irq, in_service, irq_pend, irq_en);
      end
      irq_src = 8'h00;
      tick;
      reset = 1'b0;
      repeat (LAT + 1) tick;
      tests++;
      if (cpu_irq !== 1'b0 || in_service !== 1'b0) begin
         failed++; $display("FAIL rst_stay_idle: irq=%b svc=%b expected 0/0", cpu_irq, in_service);
      end
   endtask

   initial begin
      test_reset;
      test_level_timer;
      test_priority;
      test_spurious;
      test_ack_mask_race;
      test_w1c_race;
      test_reset_mid_service;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
